pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
Fetch-stage program-counter generator for the RV32I pipeline. It holds the PC register and produces the next sequential address with a parametrised increment. It accepts branch/jump redirects from execute and trap redirects, and honours hazard-unit stalls. A redirect that arrives while the stage is stalled is stored as pending and applied when the stall releases.

Parameters:
XLEN, 32, PC/address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset (XLEN bits)
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low target bits that must be zero; these bits are forced to zero on load

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
stall_i  input  1  hazard stall; PC holds while high
redirect_i  input  1  branch/jump taken from execute
redirect_target_i  input  XLEN  branch/jump target
trap_i  input  1  trap/exception redirect request
trap_vector_i  input  XLEN  trap handler address
pc_o  output  XLEN  current fetch PC (registered)
pc_plus_o  output  XLEN  pc_o + INC, combinational, modulo 2^XLEN
pc_valid_o  output  1  pc_o is a valid fetch address
pending_o  output  1  a redirect is stored and waiting for stall release
misaligned_o  output  1  one-cycle flag: last loaded target had nonzero low ALIGN_BITS

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc_o=RESET_VECTOR, pc_valid_o=0, pending_o=0, misaligned_o=0.
  - Pending register cleared; FSM enters BOOT.
- FSM states: BOOT, RUN, HOLD.
  - BOOT: lasts exactly one clock after rst deasserts. pc_o stays RESET_VECTOR and pc_valid_o=0. Inputs are ignored. Next state is RUN.
  - RUN: pc_valid_o=1.
  - HOLD: entered when a trap or redirect arrives while stall_i=1. pending_o=1 and pc_valid_o=1.
- Next-PC priority in RUN, evaluated each clock:
  1. trap_i: load trap_vector_i.
  2. redirect_i: load redirect_target_i.
  3. Otherwise, if stall_i=0: load pc_o + INC.
  4. Otherwise: hold.
- Stall with live redirect:
  - stall_i=1 with trap_i or redirect_i: pc_o holds. The winning target (trap over redirect) is latched into the pending register, and the FSM goes to HOLD.
- Behaviour in HOLD:
  - While stall_i=1:
    - pc_o holds.
    - A new trap_i overwrites the pending target.
    - A new redirect_i overwrites the pending target only if the stored entry is not a trap.
  - When stall_i=0:
    - pc_o loads live trap_i, else live redirect_i, else the pending target.
    - Pending is cleared and the FSM returns to RUN.
- Alignment:
  - Every loaded redirect/trap/pending target has its low ALIGN_BITS forced to 0 before it enters pc_o.
  - misaligned_o=1 for exactly the cycle in which the masked PC is presented if any dropped bit was 1; otherwise misaligned_o=0.
  - Sequential increments never set misaligned_o.
- Arithmetic: pc_plus_o and sequential loads wrap modulo 2^XLEN with no overflow flag. With XLEN=32 and INC=4, 32'hFFFF_FFFC goes to 32'h0000_0000.
- Latency: a redirect or trap with stall_i=0 appears on pc_o on the next rising edge (1 cycle).

Test Plan:
- Reset then run: rst high 3 cycles, release, no stalls -> pc_valid_o=0 for 1 cycle; pc_o then reads 0x0, 0x4, 0x8, 0xC on successive cycles; pc_plus_o=pc_o+4.
- Stall hold: at pc_o=0x10 assert stall_i for 3 cycles -> pc_o stays 0x10; after release the next value is 0x14.
- Pending redirect: stall_i=1, redirect_i pulse with target 0x200, stall held 2 more cycles -> pending_o=1 and pc_o unchanged; on release pc_o=0x200 and pending_o=0.
- Trap priority: trap_i (vector 0x80) and redirect_i (0x300) in the same unstalled cycle -> pc_o=0x80. Repeat the pair under stall -> pending holds 0x80, and a later redirect 0x400 during the stall does not replace it.
- Misaligned and wrap:
  - redirect to 0x1002 -> pc_o=0x1000 with misaligned_o=1 for exactly one cycle.
  - Redirect to 0xFFFF_FFFC, no stall -> next pc_o=0x0 and misaligned_o=0.
- Async reset mid-operation: rst asserted between clock edges while pending_o=1 at pc_o=0x40 -> outputs immediately read pc_o=0x0, pending_o=0 and pc_valid_o=0, with no clock edge required.

Source files
------------

// File: rtl/pc_gen_unit_if.sv
// Fetch PC generator bus: redirect/trap/stall requests in, fetch PC and status out.
// The master drives requests; the slave (pc_gen_unit) returns the PC.
interface pc_gen_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_target_i;
  logic            trap_i;
  logic [XLEN-1:0] trap_vector_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus_o;
  logic            pc_valid_o;
  logic            pending_o;
  logic            misaligned_o;

  modport master (
    output stall_i, redirect_i, redirect_target_i, trap_i, trap_vector_i,
    input  pc_o, pc_plus_o, pc_valid_o, pending_o, misaligned_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_target_i, trap_i, trap_vector_i,
    output pc_o, pc_plus_o, pc_valid_o, pending_o, misaligned_o
  );
endinterface

// File: rtl/pc_gen_unit.sv
// RV32I fetch-stage PC generator: sequential increment, trap/redirect loads,
// and a one-entry pending redirect that is replayed when a stall releases.
module pc_gen_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  pc_gen_unit_if.slave bus
);

  localparam logic [XLEN-1:0] W_INC      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_pending;
  logic [XLEN-1:0] r_pend_target;
  logic            r_pend_is_trap;
  logic            r_misaligned;

  logic            w_live_any;
  logic [XLEN-1:0] w_live_target;
  logic [XLEN-1:0] w_release_target;

  always_comb begin
    w_live_any       = bus.trap_i | bus.redirect_i;
    w_live_target    = bus.trap_i ? bus.trap_vector_i : bus.redirect_target_i;
    w_release_target = w_live_any ? w_live_target : r_pend_target;
  end

  // Pending target is stored unmasked so misalignment is judged when it loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= BOOT;
      r_pc           <= RESET_VECTOR;
      r_valid        <= 1'b0;
      r_pending      <= 1'b0;
      r_pend_target  <= '0;
      r_pend_is_trap <= 1'b0;
      r_misaligned   <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state <= RUN;
          r_valid <= 1'b1;
        end
        RUN: begin
          if (w_live_any) begin
            if (bus.stall_i) begin
              r_pend_target  <= w_live_target;
              r_pend_is_trap <= bus.trap_i;
              r_pending      <= 1'b1;
              r_state        <= HOLD;
            end else begin
              r_pc         <= w_live_target & ALIGN_MASK;
              r_misaligned <= |(w_live_target & ~ALIGN_MASK);
            end
          end else if (!bus.stall_i) begin
            r_pc <= r_pc + W_INC;
          end
        end
        HOLD: begin
          if (bus.stall_i) begin
            if (bus.trap_i) begin
              r_pend_target  <= bus.trap_vector_i;
              r_pend_is_trap <= 1'b1;
            end else if (bus.redirect_i && !r_pend_is_trap) begin
              r_pend_target <= bus.redirect_target_i;
            end
          end else begin
            r_pc           <= w_release_target & ALIGN_MASK;
            r_misaligned   <= |(w_release_target & ~ALIGN_MASK);
            r_pending      <= 1'b0;
            r_pend_is_trap <= 1'b0;
            r_state        <= RUN;
          end
        end
        default: begin
          r_state <= BOOT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o         = r_pc;
  assign bus.pc_plus_o    = r_pc + W_INC;
  assign bus.pc_valid_o   = r_valid;
  assign bus.pending_o    = r_pending;
  assign bus.misaligned_o = r_misaligned;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit with hand-computed expectations.
module tb_pc_gen_unit;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fails;

  pc_gen_unit_if #(.XLEN(32)) bus ();

  pc_gen_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .INC(4),
    .ALIGN_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic valid,
                           input logic pend, input logic mis);
    chk({tag, ".pc"},    bus.pc_o, pc);
    chk({tag, ".valid"}, 32'(bus.pc_valid_o), 32'(valid));
    chk({tag, ".pend"},  32'(bus.pending_o), 32'(pend));
    chk({tag, ".mis"},   32'(bus.misaligned_o), 32'(mis));
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_target_i = '0;
    bus.trap_i = 1'b0;
    bus.trap_vector_i = '0;

    repeat (3) tick();
    chk_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_state("boot", 32'h0, 1'b0, 1'b0, 1'b0);

    tick();
    chk_state("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    chk("run0.plus", bus.pc_plus_o, 32'h4);
    tick(); chk("run1.pc", bus.pc_o, 32'h4);
    tick(); chk("run2.pc", bus.pc_o, 32'h8);
    tick(); chk("run3.pc", bus.pc_o, 32'hC);
    chk("run3.plus", bus.pc_plus_o, 32'h10);
    tick(); chk("run4.pc", bus.pc_o, 32'h10);

    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.pc", bus.pc_o, 32'h10);
    end
    bus.stall_i = 1'b0;
    tick(); chk("unstall.pc", bus.pc_o, 32'h14);

    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h200;
    tick();
    chk_state("pend0", 32'h14, 1'b1, 1'b1, 1'b0);
    bus.redirect_i = 1'b0;
    tick(); tick();
    chk_state("pend2", 32'h14, 1'b1, 1'b1, 1'b0);
    bus.stall_i = 1'b0;
    tick();
    chk_state("pendrel", 32'h200, 1'b1, 1'b0, 1'b0);

    bus.trap_i = 1'b1;
    bus.trap_vector_i = 32'h80;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h300;
    tick();
    chk_state("trapprio", 32'h80, 1'b1, 1'b0, 1'b0);

    bus.redirect_i = 1'b0;
    bus.trap_i = 1'b0;
    tick(); chk("seq84.pc", bus.pc_o, 32'h84);

    bus.stall_i = 1'b1;
    bus.trap_i = 1'b1;
    bus.redirect_i = 1'b1;
    tick();
    chk_state("trapstall", 32'h84, 1'b1, 1'b1, 1'b0);
    bus.trap_i = 1'b0;
    bus.redirect_target_i = 32'h400;
    tick();
    chk_state("redirlate", 32'h84, 1'b1, 1'b1, 1'b0);
    bus.redirect_i = 1'b0;
    bus.stall_i = 1'b0;
    tick();
    chk_state("traprel", 32'h80, 1'b1, 1'b0, 1'b0);

    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h1002;
    tick();
    chk_state("misal", 32'h1000, 1'b1, 1'b0, 1'b1);
    bus.redirect_i = 1'b0;
    tick();
    chk_state("misal1", 32'h1004, 1'b1, 1'b0, 1'b0);

    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h2003;
    tick();
    chk_state("pmis0", 32'h1004, 1'b1, 1'b1, 1'b0);
    bus.redirect_i = 1'b0;
    bus.stall_i = 1'b0;
    tick();
    chk_state("pmis1", 32'h2000, 1'b1, 1'b0, 1'b1);

    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'hFFFF_FFFC;
    tick();
    chk_state("wrap0", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    chk("wrap0.plus", bus.pc_plus_o, 32'h0);
    bus.redirect_i = 1'b0;
    tick();
    chk_state("wrap1", 32'h0, 1'b1, 1'b0, 1'b0);

    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h40;
    tick();
    chk("ar.pc", bus.pc_o, 32'h40);
    bus.stall_i = 1'b1;
    bus.redirect_target_i = 32'h500;
    tick();
    chk_state("ar.pend", 32'h40, 1'b1, 1'b1, 1'b0);
    bus.redirect_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_state("arst", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    bus.stall_i = 1'b0;
    tick();
    chk_state("arst.boot", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_state("arst.run", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
